// File: rtl/vdp_cpu_port.sv
// CPU-side access port of the VDP: two-byte control sequence, write FIFO, read prefetch, status.
// Optional feature: define VDP_PORT_IRQ_EN to add the vblank interrupt enable latch.
module vdp_cpu_port #(
    parameter int unsigned RamBits = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr,
    input  logic               rd,
    input  logic               portSel,
    input  logic [7:0]         dataIn,
    output logic [7:0]         dataOut,
    output logic               busy,
    output logic [RamBits-1:0] vramAddress,
    output logic [7:0]         vramDataOut,
    input  logic [7:0]         vramDataIn,
    output logic               vramReq,
    output logic               vramWrite,
    input  logic               vramGrant,
    output logic               regWrite,
    output logic [2:0]         regIndex,
    output logic [7:0]         regData,
    input  logic               vBlank,
    output logic               irq
);

    logic [RamBits-1:0] addr_q, addr_d;
    logic [1:0]         ext_q, ext_d;
    logic               toggle_q, toggle_d;
    logic [7:0]         low_q, low_d;
    logic [1:0]         count_q, count_d;
    logic [7:0]         f0_data_q, f0_data_d, f1_data_q, f1_data_d;
    logic [RamBits-1:0] f0_addr_q, f0_addr_d, f1_addr_q, f1_addr_d;
    logic               pf_pend_q, pf_pend_d;
    logic               pf_cap_q, pf_cap_d;
    logic [7:0]         pf_buf_q, pf_buf_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               reg_wr_q, reg_wr_d;
    logic [2:0]         reg_idx_q, reg_idx_d;
    logic [7:0]         reg_data_q, reg_data_d;
    logic               vb_flag_q, vb_flag_d;
    logic               vb_prev_q;
    logic               ovf_q, ovf_d;

    logic data_wr, ctrl_wr, data_rd, stat_rd;
    logic fifo_empty, fifo_full, pop, push, rd_grant, vb_rise, reg_load;
    logic [15:0] addr16, setup_addr16, ext_addr16;

    // A write in the same cycle as a read wins; the read is ignored.
    always_comb begin
        data_wr    = wr & ~portSel;
        ctrl_wr    = wr & portSel;
        data_rd    = rd & ~wr & ~portSel;
        stat_rd    = rd & ~wr & portSel;
        fifo_empty = (count_q == 2'd0);
        fifo_full  = (count_q == 2'd2);
        pop        = vramGrant & ~fifo_empty;
        rd_grant   = vramGrant & fifo_empty & pf_pend_q;
        push       = data_wr & ~fifo_full;
        vb_rise    = vBlank & ~vb_prev_q;
        reg_load   = ctrl_wr & toggle_q & (dataIn[7:6] == 2'b10);
    end

    always_comb begin
        addr_d       = addr_q;
        ext_d        = ext_q;
        toggle_d     = toggle_q;
        low_d        = low_q;
        count_d      = count_q;
        f0_data_d    = f0_data_q;
        f0_addr_d    = f0_addr_q;
        f1_data_d    = f1_data_q;
        f1_addr_d    = f1_addr_q;
        pf_pend_d    = pf_pend_q & ~rd_grant;
        pf_cap_d     = rd_grant;
        pf_buf_d     = pf_cap_q ? vramDataIn : pf_buf_q;
        rd_data_d    = rd_data_q;
        reg_wr_d     = 1'b0;
        reg_idx_d    = reg_idx_q;
        reg_data_d   = reg_data_q;
        ovf_d        = ovf_q;
        vb_flag_d    = vb_flag_q;
        addr16       = 16'(addr_q);
        setup_addr16 = {ext_q, dataIn[5:0], low_q};
        ext_addr16   = addr16;
        ext_addr16[15:14] = dataIn[1:0];

        if (pop) begin
            f0_data_d = f1_data_q;
            f0_addr_d = f1_addr_q;
            count_d   = count_q - 2'd1;
        end
        if (push) begin
            if (count_d == 2'd0) begin
                f0_data_d = dataIn;
                f0_addr_d = addr_q;
            end else begin
                f1_data_d = dataIn;
                f1_addr_d = addr_q;
            end
            count_d = count_d + 2'd1;
            addr_d  = addr_q + RamBits'(1);
        end
        if (data_wr) begin
            toggle_d = 1'b0;
            if (fifo_full) begin
                ovf_d = 1'b1;
            end
        end

        // New prefetch supersedes any read already in flight, so its data is discarded.
        if (data_rd) begin
            rd_data_d = pf_buf_q;
            addr_d    = addr_q + RamBits'(1);
            pf_pend_d = 1'b1;
            pf_cap_d  = 1'b0;
            pf_buf_d  = pf_buf_q;
            toggle_d  = 1'b0;
        end

        if (stat_rd) begin
            rd_data_d = {vb_flag_q, ovf_q, 6'b0};
            ovf_d     = 1'b0;
            vb_flag_d = 1'b0;
            toggle_d  = 1'b0;
        end

        if (ctrl_wr) begin
            if (!toggle_q) begin
                low_d    = dataIn;
                toggle_d = 1'b1;
            end else begin
                toggle_d = 1'b0;
                unique case (dataIn[7:6])
                    2'b00: begin
                        addr_d    = setup_addr16[RamBits-1:0];
                        pf_pend_d = 1'b1;
                        pf_cap_d  = 1'b0;
                        pf_buf_d  = pf_buf_q;
                    end
                    2'b01: addr_d = setup_addr16[RamBits-1:0];
                    2'b10: begin
                        reg_wr_d   = 1'b1;
                        reg_idx_d  = dataIn[2:0];
                        reg_data_d = low_q;
                    end
                    2'b11: begin
                        ext_d  = dataIn[1:0];
                        addr_d = ext_addr16[RamBits-1:0];
                    end
                    default: ;
                endcase
            end
        end

        if (vb_rise) begin
            vb_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            ext_q      <= 2'd0;
            toggle_q   <= 1'b0;
            low_q      <= 8'd0;
            count_q    <= 2'd0;
            f0_data_q  <= 8'd0;
            f0_addr_q  <= '0;
            f1_data_q  <= 8'd0;
            f1_addr_q  <= '0;
            pf_pend_q  <= 1'b0;
            pf_cap_q   <= 1'b0;
            pf_buf_q   <= 8'd0;
            rd_data_q  <= 8'd0;
            reg_wr_q   <= 1'b0;
            reg_idx_q  <= 3'd0;
            reg_data_q <= 8'd0;
            vb_flag_q  <= 1'b0;
            vb_prev_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            ext_q      <= ext_d;
            toggle_q   <= toggle_d;
            low_q      <= low_d;
            count_q    <= count_d;
            f0_data_q  <= f0_data_d;
            f0_addr_q  <= f0_addr_d;
            f1_data_q  <= f1_data_d;
            f1_addr_q  <= f1_addr_d;
            pf_pend_q  <= pf_pend_d;
            pf_cap_q   <= pf_cap_d;
            pf_buf_q   <= pf_buf_d;
            rd_data_q  <= rd_data_d;
            reg_wr_q   <= reg_wr_d;
            reg_idx_q  <= reg_idx_d;
            reg_data_q <= reg_data_d;
            vb_flag_q  <= vb_flag_d;
            vb_prev_q  <= vBlank;
            ovf_q      <= ovf_d;
        end
    end

    // Outputs are forced low combinationally while reset is held.
    always_comb begin
        dataOut     = reset ? 8'd0 : rd_data_q;
        busy        = ~reset & (fifo_full | pf_pend_q | pf_cap_q);
        vramReq     = ~reset & (~fifo_empty | pf_pend_q);
        vramWrite   = ~reset & ~fifo_empty;
        vramAddress = reset ? '0 : (fifo_empty ? addr_q : f0_addr_q);
        vramDataOut = (reset | fifo_empty) ? 8'd0 : f0_data_q;
        regWrite    = ~reset & reg_wr_q;
        regIndex    = reset ? 3'd0 : reg_idx_q;
        regData     = reset ? 8'd0 : reg_data_q;
    end

`ifdef VDP_PORT_IRQ_EN
    logic irq_en_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
        end else if (reg_load && (dataIn[2:0] == 3'd1)) begin
            irq_en_q <= low_q[5];
        end
    end

    assign irq = ~reset & vb_flag_q & irq_en_q;
`else
    assign irq = 1'b0;
`endif

endmodule
